// File: rtl/reg_access_master_pkg.sv
// ----------------------------------------------------------------------------
// reg_access_master_pkg
//
// Purpose : Shared definitions for the register access master slice.
//           Holds the FSM state encoding, the default bus geometry and
//           timeout length, the read-data value returned on an error, and
//           a helper that sizes the timeout counter.
//
// Contents:
//   state_t                 - FSM states IDLE, REQ, WAIT_RSP, RESP
//   DEFAULT_ADDR_WIDTH      - default Avalon-MM address width (16)
//   DEFAULT_DATA_WIDTH      - default data width (32)
//   DEFAULT_TIMEOUT_CYCLES  - default readdatavalid wait limit (64)
//   ERROR_RDATA             - rsp_data value for writes and timed-out reads
//   timeout_count_width()   - bits needed to count 0 .. cycles-1
// ----------------------------------------------------------------------------
package reg_access_master_pkg;

   // One-hot is not needed here: four states fit in two bits and the
   // decode is trivial.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQ      = 2'd1,
      WAIT_RSP = 2'd2,
      RESP     = 2'd3
   } state_t;

   localparam int DEFAULT_ADDR_WIDTH     = 16;
   localparam int DEFAULT_DATA_WIDTH     = 32;
   localparam int DEFAULT_TIMEOUT_CYCLES = 64;

   // Value placed on rsp_data whenever there is no real read data.
   localparam int ERROR_RDATA = 0;

   // The counter has to hold the value cycles-1; never return zero so a
   // one-cycle timeout still gets a legal one-bit vector.
   function automatic int timeout_count_width(input int cycles);
      int w;
      w = (cycles <= 2) ? 1 : $clog2(cycles);
      return w;
   endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// ----------------------------------------------------------------------------
// avalon_mm_if
//
// Purpose : Minimal Avalon-MM bundle carrying a single-beat read/write
//           transaction with waitrequest flow control and a pipelined
//           readdatavalid return path.
//
// Parameters:
//   ADDR_WIDTH - address width in bits
//   DATA_WIDTH - data width in bits
//
// Signals:
//   address, read, write, writedata  - driven by the master
//   readdata, readdatavalid,
//   waitrequest                      - driven by the slave
//
// Modports: master, slave
// ----------------------------------------------------------------------------
interface avalon_mm_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0] address;
   logic                  read;
   logic                  write;
   logic [DATA_WIDTH-1:0] writedata;
   logic [DATA_WIDTH-1:0] readdata;
   logic                  readdatavalid;
   logic                  waitrequest;

   modport master (
      output address,
      output read,
      output write,
      output writedata,
      input  readdata,
      input  readdatavalid,
      input  waitrequest
   );

   modport slave (
      input  address,
      input  read,
      input  write,
      input  writedata,
      output readdata,
      output readdatavalid,
      output waitrequest
   );

endinterface

// File: rtl/reg_access_timeout.sv
// ----------------------------------------------------------------------------
// reg_access_timeout
//
// Purpose : Counts the cycles a read spends waiting for readdatavalid and
//           flags when the wait limit has been reached. Only built when
//           REG_ACCESS_MASTER_TIMEOUT_EN is defined.
//
// Parameters:
//   TIMEOUT_CYCLES - number of waiting cycles allowed (count runs 0..N-1)
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-high reset
//   start   - pulse on the edge that enters the wait; count is 0 next cycle
//   done    - the wait is over (data arrived or timeout taken); stop
//   expired - combinational: running and the count has reached N-1
// ----------------------------------------------------------------------------
module reg_access_timeout
   import reg_access_master_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic done,
   output logic expired
);

   localparam int             CW   = timeout_count_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;
   logic          running;

   // The counter is cleared by start so the first waiting cycle sees 0.
   // It saturates at LAST so expired stays asserted until the owner
   // acknowledges with done, and done parks it back at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         running <= 1'b0;
      end else if (start) begin
         count   <= '0;
         running <= 1'b1;
      end else if (done) begin
         count   <= '0;
         running <= 1'b0;
      end else if (running && (count != LAST)) begin
         count   <= count + 1'b1;
      end
   end

   assign expired = running && (count == LAST);

endmodule

// File: rtl/reg_access_master.sv
// ----------------------------------------------------------------------------
// reg_access_master
//
// Purpose : Turns a valid/ready command stream into single Avalon-MM
//           register accesses and returns one valid/ready response per
//           command. Only one transaction is ever in flight.
//
// Build option:
//   REG_ACCESS_MASTER_TIMEOUT_EN - when defined, a read that sees no
//   readdatavalid within TIMEOUT_CYCLES waiting cycles completes with
//   rsp_error = 1. When undefined, reads wait forever and rsp_error is 0.
//
// Parameters:
//   ADDR_WIDTH     - Avalon-MM address width
//   DATA_WIDTH     - data width
//   TIMEOUT_CYCLES - readdatavalid wait limit (timeout build only)
//
// Ports:
//   clk, rst                         - clock, async active-high reset
//   cmd_valid/cmd_ready              - command handshake
//   cmd_write, cmd_addr, cmd_wdata   - command payload
//   rsp_valid/rsp_ready              - response handshake
//   rsp_data, rsp_error              - response payload
//   reg_mm                           - Avalon-MM master port
// ----------------------------------------------------------------------------
module reg_access_master
   import reg_access_master_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_error,
   avalon_mm_if.master           reg_mm
);

   // A zero-length wait makes no sense; stop the build rather than
   // produce a counter that can never express the limit.
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("reg_access_master: TIMEOUT_CYCLES must be at least 1");
   end

   state_t                state;
   logic                  read_q;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;

   // The bus outputs come straight from flops so the slave never sees
   // combinational glitches from the command side.
   assign reg_mm.address   = addr_q;
   assign reg_mm.read      = read_q;
   assign reg_mm.write     = write_q;
   assign reg_mm.writedata = wdata_q;

`ifdef REG_ACCESS_MASTER_TIMEOUT_EN
   logic timeout_start;
   logic timeout_done;
   logic timeout_expired;
   logic rsp_error_q;

   // The counter is armed on the edge where the read leaves REQ, so its
   // zero lines up with the first WAIT_RSP cycle. It is released on the
   // edge that leaves WAIT_RSP for either reason.
   assign timeout_start = (state == REQ) && read_q && !reg_mm.waitrequest;
   assign timeout_done  = (state == WAIT_RSP) &&
                          (reg_mm.readdatavalid || timeout_expired);

   reg_access_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .start   (timeout_start),
      .done    (timeout_done),
      .expired (timeout_expired)
   );

   assign rsp_error = rsp_error_q;
`else
   assign rsp_error = 1'b0;
`endif

   // Main controller. Every output is assigned here so the whole visible
   // interface changes only on a clock edge. cmd_ready is set on the edge
   // that enters IDLE, so it is already 1 in the first IDLE cycle and is
   // dropped on the same edge that accepts a command. readdatavalid is
   // only looked at in WAIT_RSP; in the timeout build it wins over an
   // expiry landing in the same cycle because it is tested first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cmd_ready   <= 1'b0;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
`ifdef REG_ACCESS_MASTER_TIMEOUT_EN
         rsp_error_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  addr_q    <= cmd_addr;
                  wdata_q   <= cmd_wdata;
                  write_q   <= cmd_write;
                  read_q    <= !cmd_write;
                  state     <= REQ;
               end
            end

            REQ: begin
               if (!reg_mm.waitrequest) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  if (write_q) begin
                     rsp_valid   <= 1'b1;
                     rsp_data    <= DATA_WIDTH'(ERROR_RDATA);
`ifdef REG_ACCESS_MASTER_TIMEOUT_EN
                     rsp_error_q <= 1'b0;
`endif
                     state       <= RESP;
                  end else begin
                     state       <= WAIT_RSP;
                  end
               end
            end

            WAIT_RSP: begin
               if (reg_mm.readdatavalid) begin
                  rsp_valid   <= 1'b1;
                  rsp_data    <= reg_mm.readdata;
`ifdef REG_ACCESS_MASTER_TIMEOUT_EN
                  rsp_error_q <= 1'b0;
`endif
                  state       <= RESP;
               end
`ifdef REG_ACCESS_MASTER_TIMEOUT_EN
               else if (timeout_expired) begin
                  rsp_valid   <= 1'b1;
                  rsp_data    <= DATA_WIDTH'(ERROR_RDATA);
                  rsp_error_q <= 1'b1;
                  state       <= RESP;
               end
`endif
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_access_master.sv
// ----------------------------------------------------------------------------
// tb_reg_access_master
//
// Directed bench for reg_access_master with TIMEOUT_CYCLES = 8. Outputs are
// sampled 1 time unit after each rising edge, inputs are driven at the same
// point, so "cycle n" below means the values seen just after edge n.
// ----------------------------------------------------------------------------
module tb_reg_access_master;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          rsp_error;

   avalon_mm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   reg_access_master #(
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_error (rsp_error),
      .reg_mm    (bus)
   );

   typedef struct {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] slave_data;
      logic [DW-1:0] exp_data;
   } vec_t;

   vec_t vecs[6];
   int   errors = 0;
   int   checks = 0;

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges the bench itself.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // One zero-wait transaction: accept in cycle 0, bus strobe in cycle 1,
   // write response in cycle 2, read data from the slave in cycle 2 and
   // read response in cycle 3. Acknowledge and confirm return to IDLE.
   task automatic applyStimulus(input vec_t v, input int idx);
      string p;
      p = $sformatf("v%0d", idx);
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      bus.readdata      = 32'hBAD0_BAD0;
      rsp_ready         = 1'b0;
      checkOutput({p, "_cmd_ready_c0"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      tick();
      cmd_valid = 1'b0;
      checkOutput({p, "_write_c1"}, 64'(bus.write), 64'(v.write));
      checkOutput({p, "_read_c1"}, 64'(bus.read), 64'(!v.write));
      checkOutput({p, "_address_c1"}, 64'(bus.address), 64'(v.addr));
      if (v.write)
         checkOutput({p, "_writedata_c1"}, 64'(bus.writedata), 64'(v.wdata));
      checkOutput({p, "_cmd_ready_c1"}, 64'(cmd_ready), 64'd0);
      tick();
      if (!v.write) begin
         checkOutput({p, "_rsp_valid_c2"}, 64'(rsp_valid), 64'd0);
         bus.readdatavalid = 1'b1;
         bus.readdata      = v.slave_data;
         tick();
         bus.readdatavalid = 1'b0;
         bus.readdata      = 32'hBAD0_BAD0;
      end
      checkOutput({p, "_strobe_off"}, 64'({bus.read, bus.write}), 64'd0);
      checkOutput({p, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
      checkOutput({p, "_rsp_data"}, 64'(rsp_data), 64'(v.exp_data));
      checkOutput({p, "_rsp_error"}, 64'(rsp_error), 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput({p, "_rsp_valid_after"}, 64'(rsp_valid), 64'd0);
      checkOutput({p, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
   endtask

   // Issue a read command and leave the DUT in WAIT_RSP at cycle 2.
   task automatic startRead(input logic [AW-1:0] addr);
      bus.waitrequest   = 1'b0;
      bus.readdatavalid = 1'b0;
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = addr;
      cmd_wdata = '0;
      tick();
      cmd_valid = 1'b0;
      tick();
   endtask

   initial begin
      vecs[0] = '{1'b1, 16'h0402, 32'hA5A5_0001, 32'h0,         32'h0};
      vecs[1] = '{1'b0, 16'h0400, 32'h0,         32'h0000_0007, 32'h0000_0007};
      vecs[2] = '{1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h0,         32'h0};
      vecs[3] = '{1'b0, 16'h0001, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF};
      vecs[4] = '{1'b0, 16'hFFFF, 32'h1234_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[5] = '{1'b1, 16'h0000, 32'h0000_0000, 32'h0,         32'h0};

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0;
      bus.waitrequest = 1'b0; bus.readdatavalid = 1'b0; bus.readdata = '0;
      tick();
      tick();

      // Reset values.
      checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_rsp_error", 64'(rsp_error), 64'd0);
      checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
      checkOutput("rst_strobes", 64'({bus.read, bus.write}), 64'd0);
      checkOutput("rst_address", 64'(bus.address), 64'd0);
      checkOutput("rst_writedata", 64'(bus.writedata), 64'd0);
      rst = 1'b0;
      tick();
      checkOutput("rst_release_cmd_ready", 64'(cmd_ready), 64'd1);

      // Table of zero-wait transactions.
      for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);

      // Write stretched by waitrequest for cycles 1..3; readdatavalid junk
      // during REQ and RESP must not leak into the write response.
      bus.waitrequest = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0123; cmd_wdata = 32'h5A5A_C3C3;
      tick();
      cmd_valid = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         checkOutput($sformatf("wr_wait_write_c%0d", c), 64'(bus.write), 64'd1);
         checkOutput($sformatf("wr_wait_addr_c%0d", c), 64'(bus.address), 64'h0123);
         checkOutput($sformatf("wr_wait_wdata_c%0d", c), 64'(bus.writedata), 64'h5A5A_C3C3);
         checkOutput($sformatf("wr_wait_rsp_valid_c%0d", c), 64'(rsp_valid), 64'd0);
         bus.readdatavalid = (c == 2);
         bus.readdata      = 32'h7777_7777;
         if (c == 4) bus.waitrequest = 1'b0;
         tick();
      end
      bus.readdatavalid = 1'b1;
      checkOutput("wr_wait_write_off", 64'(bus.write), 64'd0);
      checkOutput("wr_wait_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("wr_wait_rsp_data", 64'(rsp_data), 64'd0);
      tick();
      bus.readdatavalid = 1'b0;
      checkOutput("wr_wait_rsp_data_hold", 64'(rsp_data), 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      tick();
      tick();
      checkOutput("wr_wait_single_rsp", 64'(rsp_valid), 64'd0);

      // Read response held under back-pressure with a command waiting.
      startRead(16'h0404);
      bus.readdatavalid = 1'b1;
      bus.readdata      = 32'h1234_5678;
      tick();
      bus.readdatavalid = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0999; cmd_wdata = 32'h1;
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("bp_rsp_valid_%0d", c), 64'(rsp_valid), 64'd1);
         checkOutput($sformatf("bp_rsp_data_%0d", c), 64'(rsp_data), 64'h1234_5678);
         checkOutput($sformatf("bp_cmd_ready_%0d", c), 64'(cmd_ready), 64'd0);
         checkOutput($sformatf("bp_no_strobe_%0d", c), 64'({bus.read, bus.write}), 64'd0);
         bus.readdatavalid = (c == 1);
         bus.readdata      = 32'hFEED_0000;
         tick();
      end
      bus.readdatavalid = 1'b0;
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checkOutput("bp_rsp_valid_after", 64'(rsp_valid), 64'd0);
      checkOutput("bp_cmd_ready_after", 64'(cmd_ready), 64'd1);

`ifdef REG_ACCESS_MASTER_TIMEOUT_EN
      // Timeout: WAIT_RSP cycles 2..9 carry counts 0..7, expiry in cycle 9,
      // error response in cycle 10.
      startRead(16'h0410);
      for (int c = 2; c <= 9; c++) begin
         checkOutput($sformatf("to_wait_c%0d", c), 64'(rsp_valid), 64'd0);
         tick();
      end
      checkOutput("to_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("to_rsp_error", 64'(rsp_error), 64'd1);
      checkOutput("to_rsp_data", 64'(rsp_data), 64'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Data arriving in the expiry cycle is taken as data.
      startRead(16'h0414);
      for (int c = 2; c <= 9; c++) begin
         if (c == 9) begin
            bus.readdatavalid = 1'b1;
            bus.readdata      = 32'hCAFE_0009;
         end
         tick();
      end
      bus.readdatavalid = 1'b0;
      checkOutput("to_edge_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("to_edge_rsp_error", 64'(rsp_error), 64'd0);
      checkOutput("to_edge_rsp_data", 64'(rsp_data), 64'hCAFE_0009);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`else
      // Without the timeout a read waits as long as it takes.
      startRead(16'h0410);
      for (int c = 0; c < 30; c++) tick();
      checkOutput("nto_still_waiting", 64'(rsp_valid), 64'd0);
      checkOutput("nto_no_error", 64'(rsp_error), 64'd0);
      bus.readdatavalid = 1'b1;
      bus.readdata      = 32'hCAFE_0009;
      tick();
      bus.readdatavalid = 1'b0;
      checkOutput("nto_rsp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("nto_rsp_error", 64'(rsp_error), 64'd0);
      checkOutput("nto_rsp_data", 64'(rsp_data), 64'hCAFE_0009);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
`endif

      // Reset while waiting for read data aborts with no response.
      startRead(16'h0420);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
      checkOutput("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("mid_rst_address", 64'(bus.address), 64'd0);
      bus.readdatavalid = 1'b1;
      bus.readdata      = 32'h0BAD_0BAD;
      tick();
      tick();
      rst = 1'b0;
      bus.readdatavalid = 1'b0;
      tick();
      checkOutput("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      tick();
      tick();
      checkOutput("post_rst_no_rsp", 64'(rsp_valid), 64'd0);

      // Normal operation resumes after the aborted transaction.
      applyStimulus(vecs[1], 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/reg_access_master.md
REG_ACCESS_MASTER -- requirements
Module: reg_access_master

Interface
- REQ-001 The block SHALL have parameter ADDR_WIDTH, default 16, Avalon-MM address width in bits.
- REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, data width in bits.
- REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 64, the maximum number of cycles to wait for readdatavalid.
- REQ-004 The block SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
- REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-006 The block SHALL have port cmd_valid, input, 1 bit: a command is presented.
- REQ-007 The block SHALL have port cmd_ready, output, 1 bit: a command can be accepted.
- REQ-008 The block SHALL have port cmd_write, input, 1 bit: 1 = write, 0 = read.
- REQ-009 The block SHALL have port cmd_addr, input, ADDR_WIDTH bits: target address.
- REQ-010 The block SHALL have port cmd_wdata, input, DATA_WIDTH bits: write data.
- REQ-011 The block SHALL have port rsp_valid, output, 1 bit: a response is held.
- REQ-012 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the response.
- REQ-013 The block SHALL have port rsp_data, output, DATA_WIDTH bits: read data, or 0 for writes and errors.
- REQ-014 The block SHALL have port rsp_error, output, 1 bit: the read timed out.
- REQ-015 The block SHALL have port reg_mm, avalon_mm_if.master: it drives address, read, write and writedata, and samples readdata, readdatavalid and waitrequest.

Function
- REQ-016 The block SHALL implement the FSM states IDLE, REQ, WAIT_RSP and RESP, with all outputs registered.
- REQ-017 cmd_ready SHALL be 1 only in IDLE. When cmd_valid and cmd_ready are both 1, the block SHALL latch cmd_write, cmd_addr and cmd_wdata and go to REQ.
- REQ-018 In REQ, the block SHALL assert exactly one of read/write, together with address and writedata. It SHALL hold all of them stable while waitrequest = 1.
- REQ-019 In REQ with waitrequest = 0, the block SHALL deassert read/write on the next cycle:
  - a write goes to RESP with rsp_data = 0 and rsp_error = 0;
  - a read goes to WAIT_RSP.
- REQ-020 In WAIT_RSP, when readdatavalid = 1 the block SHALL capture readdata into rsp_data and go to RESP with rsp_error = 0.
- REQ-021 In WAIT_RSP, the timeout counter SHALL count from 0 starting on entry. If it reaches TIMEOUT_CYCLES-1 without readdatavalid, the block SHALL go to RESP with rsp_error = 1 and rsp_data = 0.
- REQ-022 If readdatavalid arrives in the same cycle the timeout expires, the block SHALL treat it as data: rsp_error = 0.
- REQ-023 In RESP, rsp_valid SHALL be 1 and rsp_data/rsp_error SHALL stay stable until rsp_ready = 1. The block then SHALL go to IDLE on the next cycle.
- REQ-024 The block SHALL ignore readdatavalid in any state other than WAIT_RSP.
- REQ-025 Latency SHALL be as follows, counting the accept cycle as 0 and assuming waitrequest = 0:
  - write: write = 1 in cycle 1, rsp_valid = 1 in cycle 2;
  - read with a slave that answers one cycle after read: read = 1 in cycle 1, readdatavalid in cycle 2, rsp_valid = 1 in cycle 3.
- REQ-026 The block SHALL accept no new command before the current response is taken, i.e. at most one transaction in flight.

Reset
- REQ-027 While rst = 1, the block SHALL immediately force the state to IDLE, and force read, write, rsp_valid, rsp_error and the timeout counter to 0.
- REQ-028 While rst = 1, cmd_ready SHALL be 0, and rsp_data, address and writedata SHALL be 0.
- REQ-029 A reset mid-transaction SHALL abort it with no response. cmd_ready SHALL return to 1 on the first cycle after rst deasserts.

Configuration
- REQ-030 With macro REG_ACCESS_MASTER_TIMEOUT_EN defined, the timeout of REQ-021 and REQ-022 SHALL be implemented.
- REQ-031 Without REG_ACCESS_MASTER_TIMEOUT_EN:
  - WAIT_RSP SHALL wait indefinitely for readdatavalid;
  - rsp_error SHALL be constant 0;
  - no timeout counter SHALL be instantiated.

Structure
- REQ-032 Package reg_access_master_pkg SHALL hold:
  - the FSM state enum;
  - the default constants for ADDR_WIDTH, DATA_WIDTH and TIMEOUT_CYCLES;
  - the error read-data value (0).
- REQ-033 The timeout counter SHALL be a sub-module, reg_access_timeout, with ports start, done and expired. It SHALL be instantiated only under REG_ACCESS_MASTER_TIMEOUT_EN.

Verification
- REQ-034 Write: cmd write, addr 0x402, wdata 0xA5A5_0001, waitrequest = 0 -> write = 1 with address 0x402 in cycle 1, rsp_valid = 1 with rsp_data = 0 in cycle 2.
- REQ-035 Read: addr 0x400, slave returns 0x0000_0007 one cycle after read -> rsp_valid = 1 with rsp_data = 0x0000_0007 and rsp_error = 0 in cycle 3.
- REQ-036 Waitrequest: waitrequest held 1 for 3 cycles on a write -> write, address and writedata stable for 4 cycles, then one response.
- REQ-037 Timeout: read with no readdatavalid, TIMEOUT_CYCLES = 8 -> rsp_error = 1 and rsp_data = 0. In a second run, readdatavalid arrives in the expiry cycle -> rsp_error = 0 with the data.
- REQ-038 Back-pressure and reset:
  - rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, and cmd_ready = 0 throughout;
  - rst pulsed during WAIT_RSP -> no rsp_valid, and cmd_ready = 1 after release.
